// File: rtl/combat_controller.sv
// Round sequencer and health/damage datapath for a one-on-one fight.
// Optional hero regeneration is built when COMBAT_REGEN_EN is defined.
module combat_controller #(
  parameter logic [7:0] MAX_HP    = 8'd20,
  parameter logic [7:0] DMG_PUNCH = 8'd2,
  parameter logic [7:0] DMG_KICK  = 8'd3,
  parameter logic [5:0] IFRAMES   = 6'd30,
  parameter logic [7:0] KO_FRAMES = 8'd120
`ifdef COMBAT_REGEN_EN
  ,
  parameter logic [7:0] REGEN_FRAMES = 8'd60
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       FrameTick,
  input  logic       Start,
  input  logic       HitH,
  input  logic       HitH_kind,
  input  logic       HitE,
  input  logic       HitE_kind,
  output logic       HitH_ack,
  output logic       HitE_ack,
  output logic [7:0] HealthH,
  output logic [7:0] HealthE,
  output logic       DeathH,
  output logic       DeathE,
  output logic       InvulnH,
  output logic       InvulnE,
  output logic [1:0] RoundState
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FIGHT   = 2'b01,
    KO_HOLD = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       reload;
  logic       ptr_e;
  logic       req_h;
  logic       req_e;
  logic       gnt_h;
  logic       gnt_e;
  logic       land_h;
  logic       land_e;
  logic       ko_now;
  logic       kind;
  logic [7:0] dmg;
  logic [7:0] hp_tgt;
  logic [7:0] hp_new;
  logic [5:0] inv_h;
  logic [5:0] inv_e;
  logic [7:0] ko_cnt;

  assign InvulnH    = (inv_h != 6'd0);
  assign InvulnE    = (inv_e != 6'd0);
  assign RoundState = state;

  // Round-robin arbitration and the shared saturating damage path
  always_comb begin
    req_h  = HitH & ~HitH_ack & (state == FIGHT);
    req_e  = HitE & ~HitE_ack & (state == FIGHT);
    gnt_h  = req_h & (~req_e | ~ptr_e);
    gnt_e  = req_e & (~req_h | ptr_e);
    kind   = gnt_h ? HitH_kind : HitE_kind;
    dmg    = kind ? DMG_KICK : DMG_PUNCH;
    hp_tgt = gnt_h ? HealthH : HealthE;
    hp_new = (dmg >= hp_tgt) ? 8'd0 : hp_tgt - dmg;
    land_h = gnt_h & ~InvulnH;
    land_e = gnt_e & ~InvulnE;
    ko_now = (land_h | land_e) & (hp_new == 8'd0);
  end

`ifdef COMBAT_REGEN_EN
  logic [7:0] regen_cnt;
  logic       regen_step;
  logic       regen_tick;

  assign regen_step = (state == FIGHT) & FrameTick & ~InvulnH;
  assign regen_tick = regen_step &
                      (regen_cnt == REGEN_FRAMES - 8'd1);

  // Frame counter pacing hero regeneration while vulnerable
  always_ff @(posedge Clk) begin
    if (Reset || reload) begin
      regen_cnt <= 8'd0;
    end else if (regen_tick) begin
      regen_cnt <= 8'd0;
    end else if (regen_step) begin
      regen_cnt <= regen_cnt + 8'd1;
    end
  end
`endif

  // Round state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Round next-state and reload decision
  always_comb begin
    state_nx = state;
    reload   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_nx = FIGHT;
          reload   = 1'b1;
        end
      end
      FIGHT: begin
        if (ko_now) begin
          state_nx = KO_HOLD;
        end
      end
      KO_HOLD: begin
        if (FrameTick && ko_cnt == KO_FRAMES - 8'd1) begin
          state_nx = OVER;
        end
      end
      OVER: begin
        if (Start) begin
          state_nx = FIGHT;
          reload   = 1'b1;
        end
      end
    endcase
  end

  // Acks, pointer, health, death flags and frame counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HitH_ack <= 1'b0;
      HitE_ack <= 1'b0;
      ptr_e    <= 1'b0;
      HealthH  <= MAX_HP;
      HealthE  <= MAX_HP;
      DeathH   <= 1'b0;
      DeathE   <= 1'b0;
      inv_h    <= 6'd0;
      inv_e    <= 6'd0;
      ko_cnt   <= 8'd0;
    end else begin
      HitH_ack <= gnt_h;
      HitE_ack <= gnt_e;
      if (gnt_h || gnt_e) begin
        ptr_e <= gnt_h;
      end
      if (land_h) begin
        HealthH <= hp_new;
        DeathH  <= (hp_new == 8'd0);
      end
`ifdef COMBAT_REGEN_EN
      else if (regen_tick && HealthH < MAX_HP) begin
        HealthH <= HealthH + 8'd1;
      end
`endif
      if (land_e) begin
        HealthE <= hp_new;
        DeathE  <= (hp_new == 8'd0);
      end
      if (land_h) begin
        inv_h <= IFRAMES;
      end else if (FrameTick && InvulnH) begin
        inv_h <= inv_h - 6'd1;
      end
      if (land_e) begin
        inv_e <= IFRAMES;
      end else if (FrameTick && InvulnE) begin
        inv_e <= inv_e - 6'd1;
      end
      if (state == KO_HOLD && FrameTick) begin
        ko_cnt <= ko_cnt + 8'd1;
      end
      if (reload) begin
        ptr_e   <= 1'b0;
        HealthH <= MAX_HP;
        HealthE <= MAX_HP;
        DeathH  <= 1'b0;
        DeathE  <= 1'b0;
        inv_h   <= 6'd0;
        inv_e   <= 6'd0;
        ko_cnt  <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_combat_controller.sv
// Directed bench for combat_controller: arbitration, damage,
// invulnerability, KO sequencing and reset.
module tb_combat_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       FrameTick;
  logic       Start;
  logic       HitH;
  logic       HitH_kind;
  logic       HitE;
  logic       HitE_kind;
  logic       HitH_ack;
  logic       HitE_ack;
  logic [7:0] HealthH;
  logic [7:0] HealthE;
  logic       DeathH;
  logic       DeathE;
  logic       InvulnH;
  logic       InvulnE;
  logic [1:0] RoundState;

  int tests  = 0;
  int failed = 0;

  combat_controller dut (
    .Clk(Clk),
    .Reset(Reset),
    .FrameTick(FrameTick),
    .Start(Start),
    .HitH(HitH),
    .HitH_kind(HitH_kind),
    .HitE(HitE),
    .HitE_kind(HitE_kind),
    .HitH_ack(HitH_ack),
    .HitE_ack(HitE_ack),
    .HealthH(HealthH),
    .HealthE(HealthE),
    .DeathH(DeathH),
    .DeathE(DeathE),
    .InvulnH(InvulnH),
    .InvulnE(InvulnE),
    .RoundState(RoundState)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      FrameTick = 1'b1;
      tick(1);
      FrameTick = 1'b0;
      tick(1);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    FrameTick = 1'b0;
    Start = 1'b0;
    HitH = 1'b0;
    HitH_kind = 1'b0;
    HitE = 1'b0;
    HitE_kind = 1'b0;
    tick(1);
    Reset = 1'b0;
  endtask

  task automatic start_round();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic hit_e(input logic k);
    HitE = 1'b1;
    HitE_kind = k;
    tick(1);
    HitE = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (RoundState !== 2'b00) begin
      failed++;
      $display("FAIL rst_state got %0d want 0", RoundState);
    end
    tests++;
    if ({HealthH, HealthE} !== {8'd20, 8'd20}) begin
      failed++;
      $display("FAIL rst_health got %0d/%0d want 20/20",
               HealthH, HealthE);
    end
    tests++;
    if ({DeathH, DeathE, InvulnH, InvulnE, HitH_ack, HitE_ack}
        !== 6'b0) begin
      failed++;
      $display("FAIL rst_flags got %b want 000000",
               {DeathH, DeathE, InvulnH, InvulnE, HitH_ack, HitE_ack});
    end
    HitH = 1'b1;
    HitE = 1'b1;
    tick(2);
    tests++;
    if ({HitH_ack, HitE_ack, RoundState} !== 4'b0000) begin
      failed++;
      $display("FAIL idle_noack got %b want 0000",
               {HitH_ack, HitE_ack, RoundState});
    end
    HitH = 1'b0;
    HitE = 1'b0;
  endtask

  task automatic test_single_hit();
    do_reset();
    start_round();
    tests++;
    if (RoundState !== 2'b01) begin
      failed++;
      $display("FAIL start_state got %0d want 1", RoundState);
    end
    HitE = 1'b1;
    HitE_kind = 1'b1;
    tick(1);
    tests++;
    if ({HitE_ack, HitH_ack, HealthE, InvulnE}
        !== {1'b1, 1'b0, 8'd17, 1'b1}) begin
      failed++;
      $display("FAIL kick_ack ack=%b health=%0d inv=%b want 1 17 1",
               HitE_ack, HealthE, InvulnE);
    end
    HitE = 1'b0;
    tick(1);
    tests++;
    if (HitE_ack !== 1'b0) begin
      failed++;
      $display("FAIL ack_one_cycle got %b want 0", HitE_ack);
    end
    frame(29);
    tests++;
    if (InvulnE !== 1'b1) begin
      failed++;
      $display("FAIL inv_29 got %b want 1", InvulnE);
    end
    frame(1);
    tests++;
    if (InvulnE !== 1'b0) begin
      failed++;
      $display("FAIL inv_30 got %b want 0", InvulnE);
    end
  endtask

  task automatic test_block();
    hit_e(1'b1);
    tests++;
    if (HealthE !== 8'd14) begin
      failed++;
      $display("FAIL second_kick got %0d want 14", HealthE);
    end
    frame(10);
    HitE = 1'b1;
    HitE_kind = 1'b0;
    tick(1);
    tests++;
    if ({HitE_ack, HealthE} !== {1'b1, 8'd14}) begin
      failed++;
      $display("FAIL blocked ack=%b health=%0d want 1 14",
               HitE_ack, HealthE);
    end
    HitE = 1'b0;
    tick(1);
    frame(19);
    tests++;
    if (InvulnE !== 1'b1) begin
      failed++;
      $display("FAIL block_inv_29 got %b want 1", InvulnE);
    end
    frame(1);
    tests++;
    if (InvulnE !== 1'b0) begin
      failed++;
      $display("FAIL block_no_reload got %b want 0", InvulnE);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    start_round();
    HitH = 1'b1;
    HitE = 1'b1;
    tick(1);
    tests++;
    if ({HitH_ack, HitE_ack, HealthH, HealthE}
        !== {2'b10, 8'd18, 8'd20}) begin
      failed++;
      $display("FAIL pair1_hero acks=%b%b hp=%0d/%0d want 10 18/20",
               HitH_ack, HitE_ack, HealthH, HealthE);
    end
    HitH = 1'b0;
    tick(1);
    tests++;
    if ({HitH_ack, HitE_ack, HealthH, HealthE}
        !== {2'b01, 8'd18, 8'd18}) begin
      failed++;
      $display("FAIL pair1_enemy acks=%b%b hp=%0d/%0d want 01 18/18",
               HitH_ack, HitE_ack, HealthH, HealthE);
    end
    HitE = 1'b0;
    tick(1);
    tests++;
    if ({HitH_ack, HitE_ack} !== 2'b00) begin
      failed++;
      $display("FAIL pair1_idle got %b%b want 00", HitH_ack, HitE_ack);
    end
    HitH = 1'b1;
    tick(1);
    tests++;
    if ({HitH_ack, HealthH} !== {1'b1, 8'd18}) begin
      failed++;
      $display("FAIL solo_hero ack=%b hp=%0d want 1 18",
               HitH_ack, HealthH);
    end
    HitH = 1'b0;
    tick(1);
    HitH = 1'b1;
    HitE = 1'b1;
    tick(1);
    tests++;
    if ({HitH_ack, HitE_ack} !== 2'b01) begin
      failed++;
      $display("FAIL pair3_first got %b%b want 01", HitH_ack, HitE_ack);
    end
    HitE = 1'b0;
    tick(1);
    tests++;
    if ({HitH_ack, HitE_ack} !== 2'b10) begin
      failed++;
      $display("FAIL pair3_second got %b%b want 10", HitH_ack, HitE_ack);
    end
    HitH = 1'b0;
    tick(1);
  endtask

  task automatic test_ko();
    do_reset();
    start_round();
    for (int i = 0; i < 6; i++) begin
      hit_e(1'b1);
      frame(30);
    end
    tests++;
    if (HealthE !== 8'd2) begin
      failed++;
      $display("FAIL ko_setup got %0d want 2", HealthE);
    end
    HitE = 1'b1;
    HitE_kind = 1'b0;
    tick(1);
    tests++;
    if ({HitE_ack, HealthE, DeathE, DeathH, RoundState}
        !== {1'b1, 8'd0, 1'b1, 1'b0, 2'b10}) begin
      failed++;
      $display("FAIL ko_edge ack=%b hp=%0d dE=%b dH=%b st=%0d want 1 0 1 0 2",
               HitE_ack, HealthE, DeathE, DeathH, RoundState);
    end
    HitE = 1'b0;
    HitH = 1'b1;
    tick(2);
    tests++;
    if ({HitH_ack, HealthH} !== {1'b0, 8'd20}) begin
      failed++;
      $display("FAIL ko_no_ack ack=%b hp=%0d want 0 20",
               HitH_ack, HealthH);
    end
    HitH = 1'b0;
    frame(119);
    tests++;
    if (RoundState !== 2'b10) begin
      failed++;
      $display("FAIL ko_hold_119 got %0d want 2", RoundState);
    end
    frame(1);
    tests++;
    if ({RoundState, DeathE, HealthE} !== {2'b11, 1'b1, 8'd0}) begin
      failed++;
      $display("FAIL over st=%0d dE=%b hp=%0d want 3 1 0",
               RoundState, DeathE, HealthE);
    end
    start_round();
    tests++;
    if ({RoundState, HealthH, HealthE, DeathH, DeathE, InvulnE}
        !== {2'b01, 8'd20, 8'd20, 3'b000}) begin
      failed++;
      $display("FAIL restart st=%0d hp=%0d/%0d flags=%b%b%b want 1 20/20 000",
               RoundState, HealthH, HealthE, DeathH, DeathE, InvulnE);
    end
  endtask

  task automatic test_reset_mid();
    HitH = 1'b1;
    HitH_kind = 1'b1;
    tick(1);
    HitH = 1'b0;
    tick(1);
    tests++;
    if ({HealthH, InvulnH} !== {8'd17, 1'b1}) begin
      failed++;
      $display("FAIL mid_setup hp=%0d inv=%b want 17 1", HealthH, InvulnH);
    end
    HitH = 1'b1;
    Reset = 1'b1;
    tick(1);
    tests++;
    if ({HitH_ack, HitE_ack, RoundState, HealthH, HealthE, InvulnH}
        !== {4'b0000, 8'd20, 8'd20, 1'b0}) begin
      failed++;
      $display("FAIL mid_reset ack=%b st=%0d hp=%0d/%0d inv=%b want 0 0 20/20 0",
               HitH_ack, RoundState, HealthH, HealthE, InvulnH);
    end
    Reset = 1'b0;
    tick(1);
    tests++;
    if ({HitH_ack, RoundState} !== 3'b000) begin
      failed++;
      $display("FAIL post_reset ack=%b st=%0d want 0 0",
               HitH_ack, RoundState);
    end
    HitH = 1'b0;
  endtask

`ifdef COMBAT_REGEN_EN
  task automatic test_regen();
    do_reset();
    start_round();
    HitH = 1'b1;
    HitH_kind = 1'b0;
    tick(1);
    HitH = 1'b0;
    tick(1);
    frame(30);
    HitH = 1'b1;
    HitH_kind = 1'b1;
    tick(1);
    HitH = 1'b0;
    tick(1);
    frame(30);
    tests++;
    if (HealthH !== 8'd15) begin
      failed++;
      $display("FAIL regen_setup got %0d want 15", HealthH);
    end
    frame(59);
    tests++;
    if (HealthH !== 8'd15) begin
      failed++;
      $display("FAIL regen_59 got %0d want 15", HealthH);
    end
    frame(1);
    tests++;
    if (HealthH !== 8'd16) begin
      failed++;
      $display("FAIL regen_60 got %0d want 16", HealthH);
    end
    frame(300);
    tests++;
    if (HealthH !== 8'd20) begin
      failed++;
      $display("FAIL regen_cap got %0d want 20", HealthH);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_block();
    test_arbitration();
    test_ko();
    test_reset_mid();
`ifdef COMBAT_REGEN_EN
    test_regen();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/combat_controller.md
Name: combat_controller

Overview:
Sequences the health/damage datapath for a one-on-one fight. Accepts hit requests against the hero and the enemy, and arbitrates them onto a single damage-update path, granting one hit per cycle with round-robin fairness. Maintains both health registers, post-hit invulnerability windows and KO detection, and runs the round FSM (idle, fight, KO hold, over). Sits between the collision/animation logic (which raises hit requests) and the HUD/game-state logic (which reads health and death flags).

Parameters:
MAX_HP, 8'd20, health loaded at round start
DMG_PUNCH, 8'd2, damage for hit kind 0
DMG_KICK, 8'd3, damage for hit kind 1
IFRAMES, 6'd30, invulnerability length in FrameTick pulses after a landed hit
KO_FRAMES, 8'd120, FrameTick pulses spent in KO_HOLD before OVER

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
FrameTick  input  1  one-Clk pulse per video frame
Start  input  1  begin round (level, sampled in IDLE/OVER)
HitH  input  1  request: hero is being hit (level, held until HitH_ack)
HitH_kind  input  1  0=punch, 1=kick; stable while HitH high
HitE  input  1  request: enemy is being hit
HitE_kind  input  1  0=punch, 1=kick
HitH_ack  output  1  one-cycle grant for HitH
HitE_ack  output  1  one-cycle grant for HitE
HealthH  output  8  hero health
HealthE  output  8  enemy health
DeathH  output  1  hero KO flag
DeathE  output  1  enemy KO flag
InvulnH  output  1  hero invulnerability window active
InvulnE  output  1  enemy invulnerability window active
RoundState  output  2  00 IDLE, 01 FIGHT, 10 KO_HOLD, 11 OVER

Behaviour:
- Reset (synchronous, takes precedence over everything else): state IDLE; HealthH=HealthE=MAX_HP; DeathH=DeathE=0; acks=0; invuln counters=0; round-robin pointer=hero; KO counter=0.
- IDLE: health held at MAX_HP. Start=1 -> FIGHT next cycle. Hit requests are not acked.
- FIGHT, arbitration: at most one ack per cycle. If only one request is high, it is granted. If both are high, the side not granted last wins, and the pointer flips after each grant. A losing request stays pending and is granted on the next cycle. Ack is registered: asserted in the cycle after it is granted, for exactly 1 cycle. After an ack, the requester must drop the request or re-raise it to start a new hit; the arbiter ignores a request in the cycle its ack is high.
- Damage: applied in the same edge that asserts the ack. new = health - dmg(kind), saturating at 0. If the target's invuln counter is nonzero, the ack is still given but health is unchanged ("blocked").
- Invuln: a landed (non-blocked) hit loads that side's counter with IFRAMES. The counter decrements on each FrameTick while nonzero. InvulnX = (counter != 0).
- KO: when a health register reaches 0, the matching Death flag is set on the same edge and the state goes to KO_HOLD. If one side reaches 0 and the other is hit in the next cycle, the second hit is not acked. Double KO cannot occur, because only one damage update happens per cycle.
- KO_HOLD: requests are ignored. The KO counter increments per FrameTick; reaching KO_FRAMES -> OVER.
- OVER: Death flags and health are held. Start=1 -> IDLE-equivalent reload (health=MAX_HP, flags, counters and pointer cleared), then FIGHT next cycle.
- Reset mid-round: full return to reset values in one cycle, and any pending ack is dropped.
- Widths: all health arithmetic is 8-bit unsigned. Damage greater than or equal to current health yields 0, with no wrap-around.

Optional Feature:
COMBAT_REGEN_EN. When defined, an added parameter REGEN_FRAMES (default 8'd60) applies: in FIGHT, the hero regains 1 HP every REGEN_FRAMES FrameTick pulses, saturating at MAX_HP. Regen pauses while InvulnH=1. If a damage grant to the hero lands in the same cycle as a regen tick, the damage is applied and the regen tick is discarded. When undefined, there is no regen logic, and health only decreases within a round.

Test Plan:
- Reset, Start, single HitE kind=1 -> HitE_ack one cycle later; HealthE 20->17; InvulnE=1 for exactly 30 FrameTicks.
- HitH and HitE raised in the same cycle, neither invulnerable -> hero acked first, enemy next cycle; HealthH=18, HealthE=18; third simultaneous pair is granted in the order enemy first, then hero.
- Second HitE (kind 0) arriving within the 30-frame window -> acked, HealthE unchanged, InvulnE counter not reloaded.
- Drive HealthE to 2, then punch -> HealthE=0, DeathE=1, RoundState=KO_HOLD; subsequent HitH not acked; after 120 FrameTicks RoundState=OVER; Start -> both health values 20, flags 0, FIGHT.
- Reset asserted in FIGHT with HitH pending -> next cycle all outputs at reset values, no ack.
- With COMBAT_REGEN_EN: HealthH=15, no hits, 60 FrameTicks -> HealthH=16; at HealthH=20 it stays 20.
